vga_timing_gen: RTL and testbench

//  Parametrised raster timing generator; successor of the fixed 640x480 HVGEN.

---
 rtl/vga_timing_gen.sv | 96 +++++++++
 tb/tb_vga_timing_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with sync, data-enable, blanking, frame/line strobes and line prefetch
module vga_timing_gen #(
  parameter int   CW       = 10,
  parameter int   HACT     = 640,
  parameter int   HFP      = 16,
  parameter int   HSW      = 96,
  parameter int   HBP      = 48,
  parameter int   VACT     = 480,
  parameter int   VFP      = 10,
  parameter int   VSW      = 2,
  parameter int   VBP      = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   PREFETCH = 8
) (
  input  logic          pck,
  input  logic          rst,
  input  logic          ce,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          de,
  output logic          vblank,
  output logic          frame_start,
  output logic          line_req,
  output logic [CW-1:0] req_y
);
  localparam int HTOTAL = HACT + HFP + HSW + HBP;
  localparam int VTOTAL = VACT + VFP + VSW + VBP;
  localparam logic [CW-1:0] H_LAST = CW'(HTOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(VTOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(HACT);
  localparam logic [CW-1:0] V_ACT  = CW'(VACT);
  localparam logic [CW-1:0] HS_BEG = CW'(HACT + HFP);
  localparam logic [CW-1:0] HS_END = CW'(HACT + HFP + HSW - 1);
  localparam logic [CW-1:0] VS_BEG = CW'(VACT + VFP);
  localparam logic [CW-1:0] VS_END = CW'(VACT + VFP + VSW - 1);
  localparam logic [CW-1:0] H_REQ  = CW'(HTOTAL - PREFETCH);

  if (HTOTAL > (1 << CW) || VTOTAL > (1 << CW) || PREFETCH < 1 || PREFETCH > HBP) begin : g_bad_params
    $error("vga_timing_gen: HTOTAL/VTOTAL exceed CW bits or PREFETCH outside 1..HBP");
  end

  logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d, req_y_q, req_y_d, next_y;
  logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d, vblank_q, vblank_d;
  logic          fs_q, fs_d, lr_q, lr_d;

  // Levels and strobe conditions come from the next counter values so they line up with hcnt/vcnt
  always_comb begin
    hcnt_d   = !ce ? hcnt_q : (hcnt_q == H_LAST) ? '0 : hcnt_q + 1'b1;
    vcnt_d   = (!ce || hcnt_q != H_LAST) ? vcnt_q : (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    next_y   = (vcnt_d == V_LAST) ? '0 : vcnt_d + 1'b1;
    hs_d     = (hcnt_d >= HS_BEG && hcnt_d <= HS_END) ? HS_POL : ~HS_POL;
    vs_d     = (vcnt_d >= VS_BEG && vcnt_d <= VS_END) ? VS_POL : ~VS_POL;
    de_d     = hcnt_d < H_ACT && vcnt_d < V_ACT;
    vblank_d = vcnt_d >= V_ACT;
    fs_d     = hcnt_d == '0 && vcnt_d == '0;
    lr_d     = hcnt_d == H_REQ && next_y < V_ACT;
    req_y_d  = next_y;
  end

  always_ff @(posedge pck or negedge rst) begin
    if (!rst) begin
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      de_q     <= 1'b1;
      vblank_q <= 1'b0;
      fs_q     <= 1'b1;
      lr_q     <= 1'b0;
      req_y_q  <= '0;
    end else begin
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      de_q     <= de_d;
      vblank_q <= vblank_d;
      fs_q     <= fs_d;
      lr_q     <= lr_d;
      req_y_q  <= req_y_d;
    end
  end

  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign de          = de_q;
  assign vblank      = vblank_q;
  assign frame_start = fs_q & ce;
  assign line_req    = lr_q & ce;
  assign req_y       = req_y_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: drives VGA, small and NES-style generators in lockstep against a pixel-index raster model
module tb_vga_timing_gen;
  localparam int  HACT_C[3] = '{640, 20, 256};
  localparam int  HFP_C[3]  = '{16, 3, 16};
  localparam int  HSW_C[3]  = '{96, 4, 24};
  localparam int  HBP_C[3]  = '{48, 5, 40};
  localparam int  VACT_C[3] = '{480, 12, 240};
  localparam int  VFP_C[3]  = '{10, 2, 3};
  localparam int  VSW_C[3]  = '{2, 2, 3};
  localparam int  VBP_C[3]  = '{33, 3, 16};
  localparam bit  HP_C[3]   = '{1'b0, 1'b0, 1'b1};
  localparam bit  VP_C[3]   = '{1'b0, 1'b1, 1'b1};
  localparam int  PF_C[3]   = '{8, 5, 1};

  logic       pck, rst, ce;
  logic [9:0] hc [3], vc [3], ry [3];
  logic       hs [3], vs [3], de [3], vb [3], fs [3], lr [3];
  logic [34:0] obs [3];
  int n, checks, errors;

  always #5 pck = ~pck;

  vga_timing_gen u_vga (.pck(pck), .rst(rst), .ce(ce), .hcnt(hc[0]), .vcnt(vc[0]), .vga_hs(hs[0]),
    .vga_vs(vs[0]), .de(de[0]), .vblank(vb[0]), .frame_start(fs[0]), .line_req(lr[0]), .req_y(ry[0]));

  vga_timing_gen #(.HACT(HACT_C[1]), .HFP(HFP_C[1]), .HSW(HSW_C[1]), .HBP(HBP_C[1]), .VACT(VACT_C[1]),
    .VFP(VFP_C[1]), .VSW(VSW_C[1]), .VBP(VBP_C[1]), .HS_POL(HP_C[1]), .VS_POL(VP_C[1]), .PREFETCH(PF_C[1]))
  u_small (.pck(pck), .rst(rst), .ce(ce), .hcnt(hc[1]), .vcnt(vc[1]), .vga_hs(hs[1]),
    .vga_vs(vs[1]), .de(de[1]), .vblank(vb[1]), .frame_start(fs[1]), .line_req(lr[1]), .req_y(ry[1]));

  vga_timing_gen #(.HACT(HACT_C[2]), .HFP(HFP_C[2]), .HSW(HSW_C[2]), .HBP(HBP_C[2]), .VACT(VACT_C[2]),
    .VFP(VFP_C[2]), .VSW(VSW_C[2]), .VBP(VBP_C[2]), .HS_POL(HP_C[2]), .VS_POL(VP_C[2]), .PREFETCH(PF_C[2]))
  u_nes (.pck(pck), .rst(rst), .ce(ce), .hcnt(hc[2]), .vcnt(vc[2]), .vga_hs(hs[2]),
    .vga_vs(vs[2]), .de(de[2]), .vblank(vb[2]), .frame_start(fs[2]), .line_req(lr[2]), .req_y(ry[2]));

  for (genvar g = 0; g < 3; g++) begin : g_obs
    assign obs[g] = {hc[g], vc[g], hs[g], vs[g], de[g], vb[g], fs[g], lr[g], lr[g] ? ry[g] : 10'd0};
  end

  // Expected outputs after n advancing pixels since reset, with ce currently c
  function automatic logic [34:0] model(input int k, input int px, input logic c);
    int ht, vt, h, v, ny;
    logic hs_e, vs_e, lr_e;
    ht = HACT_C[k] + HFP_C[k] + HSW_C[k] + HBP_C[k];
    vt = VACT_C[k] + VFP_C[k] + VSW_C[k] + VBP_C[k];
    h = px % ht;
    v = (px / ht) % vt;
    ny = (v + 1) % vt;
    hs_e = (h >= HACT_C[k] + HFP_C[k] && h < HACT_C[k] + HFP_C[k] + HSW_C[k]) ? HP_C[k] : !HP_C[k];
    vs_e = (v >= VACT_C[k] + VFP_C[k] && v < VACT_C[k] + VFP_C[k] + VSW_C[k]) ? VP_C[k] : !VP_C[k];
    lr_e = c && h == ht - PF_C[k] && ny < VACT_C[k];
    return {10'(h), 10'(v), hs_e, vs_e, h < HACT_C[k] && v < VACT_C[k], v >= VACT_C[k],
            c && h == 0 && v == 0, lr_e, lr_e ? 10'(ny) : 10'd0};
  endfunction

  task automatic do_reset();
    @(negedge pck);
    rst = 1'b0;
    ce = 1'b0;
    @(negedge pck);
    rst = 1'b1;
    n = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ce = 1'b0;
    repeat (3) @(negedge pck);
    for (int c = 0; c < 2; c++) begin
      ce = c[0];
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== model(k, 0, ce)) begin
          errors++;
          $display("FAIL reset dut%0d ce=%0d got=%h exp=%h", k, ce, obs[k], model(k, 0, ce));
        end
      end
    end
    @(negedge pck);
    rst = 1'b1;
    ce = 1'b0;
    n = 0;
  endtask

  task automatic test_full_ce();
    for (int i = 0; i < 2000; i++) begin
      @(negedge pck);
      ce = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== model(k, n, ce)) begin
          errors++;
          $display("FAIL full dut%0d n=%0d got=%h exp=%h", k, n, obs[k], model(k, n, ce));
        end
      end
      n++;
    end
  endtask

  task automatic test_ce_toggle();
    int last = -1;
    int period = 2 * (HACT_C[1] + HFP_C[1] + HSW_C[1] + HBP_C[1]) * (VACT_C[1] + VFP_C[1] + VSW_C[1] + VBP_C[1]);
    int seen = 0;
    for (int i = 0; i < 2600; i++) begin
      @(negedge pck);
      ce = (i % 2) == 0;
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== model(k, n, ce)) begin
          errors++;
          $display("FAIL toggle dut%0d n=%0d ce=%0d got=%h exp=%h", k, n, ce, obs[k], model(k, n, ce));
        end
      end
      if (fs[1]) begin
        if (last >= 0) begin
          checks++;
          seen++;
          if (i - last !== period) begin
            errors++;
            $display("FAIL toggle_period got=%0d exp=%0d", i - last, period);
          end
        end
        last = i;
      end
      if (ce) n++;
    end
    checks++;
    if (seen < 1) begin
      errors++;
      $display("FAIL toggle_period_seen got=%0d exp>=1", seen);
    end
  endtask

  task automatic test_random_ce();
    for (int i = 0; i < 3000; i++) begin
      @(negedge pck);
      ce = $urandom_range(0, 3) != 0;
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== model(k, n, ce)) begin
          errors++;
          $display("FAIL random dut%0d n=%0d ce=%0d got=%h exp=%h", k, n, ce, obs[k], model(k, n, ce));
        end
      end
      if (ce) n++;
    end
  endtask

  task automatic test_frame_counts();
    int de_n = 0, hs_n = 0, vs_n = 0, fs_n = 0, lr_n = 0;
    do_reset();
    for (int i = 0; i < 32 * 19; i++) begin
      @(negedge pck);
      ce = 1'b1;
      #1;
      de_n += int'(de[1]);
      hs_n += int'(hs[1] == 1'b0);
      vs_n += int'(vs[1] == 1'b1);
      fs_n += int'(fs[1]);
      lr_n += int'(lr[1]);
      n++;
    end
    checks += 5;
    if (de_n !== 240) begin errors++; $display("FAIL count_de got=%0d exp=240", de_n); end
    if (hs_n !== 76) begin errors++; $display("FAIL count_hs got=%0d exp=76", hs_n); end
    if (vs_n !== 64) begin errors++; $display("FAIL count_vs got=%0d exp=64", vs_n); end
    if (fs_n !== 1) begin errors++; $display("FAIL count_fs got=%0d exp=1", fs_n); end
    if (lr_n !== 12) begin errors++; $display("FAIL count_lr got=%0d exp=12", lr_n); end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (800 + 700) begin
      @(negedge pck);
      ce = 1'b1;
      n++;
    end
    @(negedge pck);
    #1;
    checks++;
    if (hc[0] !== 10'd700 || vc[0] !== 10'd1) begin
      errors++;
      $display("FAIL async_pre got=%0d,%0d exp=700,1", hc[0], vc[0]);
    end
    #2;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== model(k, 0, ce)) begin
        errors++;
        $display("FAIL async_assert dut%0d got=%h exp=%h", k, obs[k], model(k, 0, ce));
      end
    end
    @(negedge pck);
    ce = 1'b0;
    @(negedge pck);
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge pck);
      ce = i > 2;
      #1;
      if (i == 3) begin
        checks++;
        if (fs[0] !== 1'b1) begin errors++; $display("FAIL async_first_fs got=%b exp=1", fs[0]); end
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== model(k, n, ce)) begin
          errors++;
          $display("FAIL async_after dut%0d n=%0d got=%h exp=%h", k, n, obs[k], model(k, n, ce));
        end
      end
      if (ce) n++;
    end
  endtask

  initial begin
    pck = 1'b0;
    rst = 1'b0;
    ce = 1'b0;
    n = 0;
    checks = 0;
    errors = 0;
    test_reset();
    test_full_ce();
    test_ce_toggle();
    test_random_ce();
    test_frame_counts();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
